// File: rtl/alu_pkg.sv
// Shared ALU op encodings and controller FSM states; the ALU datapath uses
// the same 2-bit op codes.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_acc_datapath.sv
// Combinational accumulator ALU: applies op (or a load) to acc and operand,
// producing the result, carry/borrow and zero flag.
module alu_acc_datapath
  import alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              load,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  // One extra bit holds the ADD carry; for SUB it wraps to 1 exactly when acc < operand
  always_comb begin
    wide = '0;
    if (load) begin
      wide = {1'b0, operand};
    end else begin
      case (op)
        OP_AND:  wide = {1'b0, acc & operand};
        OP_OR:   wide = {1'b0, acc | operand};
        OP_ADD:  wide = {1'b0, acc} + {1'b0, operand};
        OP_SUB:  wide = {1'b0, acc} - {1'b0, operand};
        default: wide = '0;
      endcase
    end
  end

  assign result = wide[DATA_W-1:0];
  assign carry  = wide[DATA_W];
  assign zero   = (result == '0);

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator command controller: one command per handshake, result returned
// on a held valid/ready response channel, completed responses counted.
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_operand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [CNT_W-1:0]  op_count
);

  state_e state, next_state;

  logic              cmd_load;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_operand;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] dp_result;
  logic              dp_carry;
  logic              dp_zero;

  alu_acc_datapath #(
    .DATA_W(DATA_W)
  ) u_datapath (
    .acc    (acc),
    .operand(cmd_operand),
    .load   (cmd_load),
    .op     (cmd_op),
    .result (dp_result),
    .carry  (dp_carry),
    .zero   (dp_zero)
  );

  // Handshake flags come from the registered state only
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command capture, accumulator/response update and completion counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_load    <= 1'b0;
      cmd_op      <= '0;
      cmd_operand <= '0;
      acc         <= '0;
      rsp_data    <= '0;
      rsp_carry   <= 1'b0;
      rsp_zero    <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_load    <= req_load;
            cmd_op      <= req_op;
            cmd_operand <= req_operand;
          end
        end
        EXEC: begin
          acc       <= dp_result;
          rsp_data  <= dp_result;
          rsp_carry <= dp_carry;
          rsp_zero  <= dp_zero;
        end
        RESP: begin
          if (rsp_ready) op_count <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl with hand-computed expected responses.
module tb_alu_acc_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_load;
  logic [1:0] req_op;
  logic [3:0] req_operand;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [7:0] op_count;

  int tests_run = 0;
  int tests_failed = 0;

  alu_acc_ctrl #(.DATA_W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_op     (req_op),
    .req_operand(req_operand),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is high
  task automatic applyStimulus(input logic load, input logic [1:0] op, input logic [3:0] operand);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    checkOutput("req_ready_wait", req_ready, 1);
    req_valid   = 1'b1;
    req_load    = load;
    req_op      = op;
    req_operand = operand;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checkOutput("rsp_valid_wait", rsp_valid, 1);
  endtask

  task automatic complete_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] data, input logic carry, input logic zero);
    checkOutput({tag, "_data"}, rsp_data, data);
    checkOutput({tag, "_carry"}, rsp_carry, carry);
    checkOutput({tag, "_zero"}, rsp_zero, zero);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_op = OP_AND;
    req_operand = 4'd0; rsp_ready = 1'b0;
    #12;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    check_rsp("reset", 4'd0, 1'b0, 1'b0);
    checkOutput("reset_op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, OP_AND, 4'd9);
    check_rsp("load9", 4'd9, 1'b0, 1'b0);
    complete_rsp();
    applyStimulus(1'b0, OP_ADD, 4'd9);
    check_rsp("add9", 4'd2, 1'b1, 1'b0);
    complete_rsp();
    checkOutput("count_after_add", op_count, 2);

    applyStimulus(1'b1, OP_ADD, 4'd3);
    complete_rsp();
    applyStimulus(1'b0, OP_SUB, 4'd5);
    check_rsp("sub5", 4'd14, 1'b1, 1'b0);
    complete_rsp();
    applyStimulus(1'b0, OP_SUB, 4'd14);
    check_rsp("sub14", 4'd0, 1'b0, 1'b1);
    complete_rsp();

    applyStimulus(1'b1, OP_SUB, 4'd12);
    check_rsp("load12", 4'd12, 1'b0, 1'b0);
    complete_rsp();
    applyStimulus(1'b0, OP_AND, 4'd10);
    check_rsp("and10", 4'd8, 1'b0, 1'b0);
    complete_rsp();
    applyStimulus(1'b0, OP_OR, 4'd3);
    check_rsp("or3", 4'd11, 1'b0, 1'b0);
    complete_rsp();
    checkOutput("count_after_logic", op_count, 8);

    // Backpressure: response held for 5 cycles, acc 11 + 1 = 12
    applyStimulus(1'b0, OP_ADD, 4'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_data", rsp_data, 4'd12);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_op_count", op_count, 8);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_count", op_count, 9);
    checkOutput("bp_release_req_ready", req_ready, 1);
    checkOutput("bp_release_rsp_valid", rsp_valid, 0);
    @(negedge clk);

    // Back-to-back: four ADD 1 commands, accepted every 3 cycles
    req_valid = 1'b1; req_load = 1'b0; req_op = OP_ADD; req_operand = 4'd1;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] exp_data;
      exp_data = 4'(13 + i / 3);
      checkOutput("tp_req_ready", req_ready, (i % 3 == 0) ? 1 : 0);
      checkOutput("tp_rsp_valid", rsp_valid, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2) begin
        checkOutput("tp_rsp_data", rsp_data, exp_data);
        checkOutput("tp_rsp_carry", rsp_carry, (i == 11) ? 1 : 0);
      end
      if (i == 11) req_valid = 1'b0;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checkOutput("tp_op_count", op_count, 13);
    checkOutput("tp_idle_rsp_valid", rsp_valid, 0);

    // Asynchronous reset while a response is pending
    applyStimulus(1'b1, OP_AND, 4'd7);
    check_rsp("pre_reset", 4'd7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rsp_valid", rsp_valid, 0);
    checkOutput("async_req_ready", req_ready, 1);
    check_rsp("async", 4'd0, 1'b0, 1'b0);
    checkOutput("async_op_count", op_count, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 4'd5);
    check_rsp("add5_after_reset", 4'd5, 1'b0, 1'b0);
    complete_rsp();
    checkOutput("count_after_reset", op_count, 1);

    // Counter wrap: 255 more responses bring it through 255 back to 0
    for (int i = 0; i < 254; i++) begin
      applyStimulus(1'b0, OP_OR, 4'd0);
      complete_rsp();
    end
    checkOutput("count_255", op_count, 255);
    applyStimulus(1'b0, OP_OR, 4'd0);
    complete_rsp();
    checkOutput("count_wrap", op_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
